// File: rtl/link_vc_scheduler.sv
// Shares one registered router-to-router link between VC_NUM virtual channels.
// Round-robin picks one eligible VC per cycle; per-VC packet state keeps heads on free downstream VCs.
module link_vc_scheduler #(
  parameter int VC_NUM = 2,
  parameter int FLIT_W = 64,
  localparam int VC_W  = $clog2(VC_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [VC_NUM-1:0]        req_valid_i,
  input  logic [VC_NUM*FLIT_W-1:0] req_flit_i,
  input  logic [VC_NUM-1:0]        req_head_i,
  input  logic [VC_NUM-1:0]        req_tail_i,
  output logic [VC_NUM-1:0]        grant_o,
  output logic [FLIT_W-1:0]        link_flit_o,
  output logic                     link_valid_o,
  output logic [VC_W-1:0]          link_vc_o,
  input  logic [VC_NUM-1:0]        link_on_off_i,
  input  logic [VC_NUM-1:0]        link_allocatable_i,
  output logic                     proto_err_o,
  output logic [VC_NUM-1:0]        dbg_state_o,
  output logic [VC_W-1:0]          dbg_rr_ptr_o
);

  // Handshake: req_valid_i[v] is a request; grant_o[v] in the same cycle means the
  // upstream buffer must pop that flit at the coming edge. Nothing else is a transfer.

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

  vc_state_e        state_q [VC_NUM];
  vc_state_e        state_d [VC_NUM];
  logic [VC_W-1:0]  rr_ptr_q;
  logic [VC_W-1:0]  rr_ptr_d;
  logic [VC_NUM-1:0] legal;
  logic [VC_NUM-1:0] illegal;
  logic [VC_NUM-1:0] elig;
  logic              gnt_any;
  logic [VC_W-1:0]   gnt_idx;

  always_comb begin
    legal   = '0;
    illegal = '0;
    elig    = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (state_q[v] == VC_IDLE) begin
        legal[v]   = req_head_i[v] & link_allocatable_i[v];
        illegal[v] = req_valid_i[v] & ~req_head_i[v];
      end else begin
        legal[v]   = ~req_head_i[v];
        illegal[v] = req_valid_i[v] & req_head_i[v];
      end
      elig[v] = req_valid_i[v] & link_on_off_i[v] & legal[v];
    end
  end

  // First eligible VC at or after rr_ptr, wrapping modulo VC_NUM.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      idx = (int'(rr_ptr_q) + i) % VC_NUM;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = VC_W'(idx);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (gnt_any && rst_n) grant_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) state_d[v] = state_q[v];
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      case (state_q[gnt_idx])
        VC_IDLE:   if (!req_tail_i[gnt_idx]) state_d[gnt_idx] = VC_ACTIVE;
        VC_ACTIVE: if (req_tail_i[gnt_idx])  state_d[gnt_idx] = VC_IDLE;
        default:   state_d[gnt_idx] = VC_IDLE;
      endcase
      rr_ptr_d = (gnt_idx == VC_W'(VC_NUM - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VC_NUM; v++) state_q[v] <= VC_IDLE;
      rr_ptr_q     <= '0;
      link_valid_o <= 1'b0;
      link_flit_o  <= '0;
      link_vc_o    <= '0;
      proto_err_o  <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) state_q[v] <= state_d[v];
      rr_ptr_q     <= rr_ptr_d;
      link_valid_o <= gnt_any;
      if (gnt_any) begin
        link_flit_o <= req_flit_i[int'(gnt_idx)*FLIT_W +: FLIT_W];
        link_vc_o   <= gnt_idx;
      end
      // Sticky: only reset clears a protocol violation.
      if (|illegal) proto_err_o <= 1'b1;
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) dbg_state_o[v] = (state_q[v] == VC_ACTIVE);
  end

  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_link_vc_scheduler.sv
// Bench for link_vc_scheduler (4 VCs): directed scenarios plus randomized traffic,
// all compared against a packet-level reference model of the link.
module tb_link_vc_scheduler;
  localparam int N  = 4;
  localparam int FW = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_head, req_tail, on_off, alloc;
  logic [N*FW-1:0] req_flit;
  logic [N-1:0]  grant_o;
  logic [FW-1:0] link_flit_o;
  logic          link_valid_o;
  logic [1:0]    link_vc_o;
  logic          proto_err_o;
  logic [N-1:0]  dbg_state_o;
  logic [1:0]    dbg_rr_ptr_o;

  link_vc_scheduler #(.VC_NUM(N), .FLIT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_flit_i(req_flit),
    .req_head_i(req_head), .req_tail_i(req_tail),
    .grant_o(grant_o), .link_flit_o(link_flit_o),
    .link_valid_o(link_valid_o), .link_vc_o(link_vc_o),
    .link_on_off_i(on_off), .link_allocatable_i(alloc),
    .proto_err_o(proto_err_o),
    .dbg_state_o(dbg_state_o), .dbg_rr_ptr_o(dbg_rr_ptr_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // upstream packet sources
  int          src_len  [N];
  int          src_pos  [N];
  logic [FW-1:0] src_flit [N];
  bit          src_drop [N];

  // reference model: open-packet flags, round-robin pointer, link register contents
  bit          m_open [N];
  int          m_rr;
  bit          m_err;
  bit          m_lv;
  int          m_lvc;
  logic [FW-1:0] m_lflit;

  logic [N-1:0] last_grant;
  int           link_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_packet(input int v, input int len);
    src_len[v]  = len;
    src_pos[v]  = 0;
    src_flit[v] = FW'($urandom);
  endtask

  task automatic apply_sources();
    for (int v = 0; v < N; v++) begin
      req_valid[v] = (src_pos[v] < src_len[v]) && !src_drop[v];
      req_head[v]  = (src_pos[v] == 0);
      req_tail[v]  = (src_pos[v] == src_len[v] - 1);
      req_flit[v*FW +: FW] = src_flit[v];
    end
  endtask

  // A VC may send when it is on and its flit fits the packet: heads only start a packet
  // on a free downstream VC, non-heads only continue an open one.
  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      int v;
      bit ok;
      v  = (m_rr + k) % N;
      ok = req_valid[v] && on_off[v] &&
           (m_open[v] ? !req_head[v] : (req_head[v] && alloc[v]));
      if (ok) return v;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_state();
    logic [N-1:0] s;
    for (int v = 0; v < N; v++) s[v] = m_open[v];
    return s;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_open[v]   = 0;
      src_len[v]  = 0;
      src_pos[v]  = 0;
      src_drop[v] = 0;
    end
    m_rr = 0; m_err = 0; m_lv = 0; m_lvc = 0; m_lflit = '0;
  endtask

  // One clock: check grant mid-cycle, advance model, check registered outputs after the edge.
  task automatic step();
    int g;
    logic [N-1:0] eg;
    #1;
    g  = model_pick();
    eg = (g >= 0) ? (N'(1) << g) : '0;
    last_grant = grant_o;
    check("grant", grant_o, eg);
    for (int v = 0; v < N; v++)
      if (req_valid[v] && (m_open[v] ? req_head[v] : !req_head[v])) m_err = 1;
    if (g >= 0) begin
      m_lv    = 1;
      m_lvc   = g;
      m_lflit = req_flit[g*FW +: FW];
      if (req_head[g]) m_open[g] = !req_tail[g];
      else if (req_tail[g]) m_open[g] = 0;
      m_rr = (g + 1) % N;
    end else begin
      m_lv = 0;
    end
    @(posedge clk);
    #1;
    check("link_valid", link_valid_o, m_lv);
    check("link_vc", link_vc_o, m_lvc);
    check("link_flit", link_flit_o, m_lflit);
    check("proto_err", proto_err_o, m_err);
    check("vc_state", dbg_state_o, model_state());
    check("rr_ptr", dbg_rr_ptr_o, m_rr);
    if (link_valid_o) link_count++;
    if (g >= 0) begin
      src_pos[g]++;
      src_flit[g] = FW'($urandom);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_head = '0; req_tail = '0; req_flit = '0;
    on_off = '1; alloc = '1;
    last_grant = '0; link_count = 0;
    model_reset();

    // reset values
    repeat (2) @(negedge clk);
    check("rst_link_valid", link_valid_o, 0);
    check("rst_link_flit", link_flit_o, 0);
    check("rst_link_vc", link_vc_o, 0);
    check("rst_proto_err", proto_err_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_state", dbg_state_o, 0);
    check("rst_rr", dbg_rr_ptr_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // two VCs, 3-flit packets each: strict alternation, six link cycles
    new_packet(0, 3);
    new_packet(1, 3);
    link_count = 0;
    for (int k = 0; k < 6; k++) begin
      apply_sources();
      step();
      check("alt_grant", last_grant, N'(1) << (k % 2));
    end
    apply_sources();
    step();
    check("alt_link_cycles", link_count, 6);

    // on/off back-pressure holds a pending body flit
    new_packet(0, 3);
    apply_sources();
    step();
    check("onoff_head", last_grant, 4'b0001);
    on_off[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apply_sources();
      step();
      check("onoff_hold_grant", last_grant, 0);
      check("onoff_hold_valid", link_valid_o, 0);
    end
    on_off[0] = 1'b1;
    apply_sources();
    step();
    check("onoff_resume", last_grant, 4'b0001);
    apply_sources();
    step();

    // head waits for a free downstream VC
    new_packet(1, 2);
    alloc[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply_sources();
      step();
      check("alloc_hold", last_grant, 0);
    end
    alloc[1] = 1'b1;
    apply_sources();
    step();
    check("alloc_grant", last_grant, 4'b0010);
    check("alloc_active", dbg_state_o[1], 1'b1);
    apply_sources();
    step();

    // body flit on an idle VC is a protocol error, never granted, sticky
    apply_sources();
    req_valid[0] = 1'b1; req_head[0] = 1'b0; req_tail[0] = 1'b0;
    step();
    check("err_no_grant", last_grant, 0);
    check("err_set", proto_err_o, 1'b1);

    // pointer at 3 with VC3 and VC0 eligible: VC3 first, then wrap to VC0
    new_packet(2, 1);
    apply_sources();
    step();
    check("wrap_pre", dbg_rr_ptr_o, 2'd3);
    new_packet(3, 1);
    new_packet(0, 1);
    apply_sources();
    step();
    check("wrap_grant3", last_grant, 4'b1000);
    check("wrap_rr0", dbg_rr_ptr_o, 2'd0);
    apply_sources();
    step();
    check("wrap_grant0", last_grant, 4'b0001);
    check("err_sticky", proto_err_o, 1'b1);

    // asynchronous reset in the middle of traffic
    new_packet(0, 4);
    new_packet(1, 4);
    apply_sources();
    step();
    apply_sources();
    step();
    apply_sources();
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", grant_o, 0);
    check("async_link_valid", link_valid_o, 0);
    check("async_proto_err", proto_err_o, 0);
    check("async_state", dbg_state_o, 0);
    model_reset();
    apply_sources();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic with random back-pressure and request bubbles
    for (int c = 0; c < 400; c++) begin
      for (int v = 0; v < N; v++) begin
        if (src_pos[v] >= src_len[v] && $urandom_range(0, 3) == 0)
          new_packet(v, $urandom_range(1, 4));
        src_drop[v] = ($urandom_range(0, 5) == 0);
        on_off[v]   = ($urandom_range(0, 4) != 0);
        alloc[v]    = ($urandom_range(0, 3) != 0);
      end
      apply_sources();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
